// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory port:
// funct3 codes, FSM states and access helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } lsu_state_t;

    // Access size in bytes from the width bits of funct3.
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        logic [2:0] sz;
        case (f3[1:0])
            2'b00:   sz = 3'd1;
            2'b01:   sz = 3'd2;
            default: sz = 3'd4;
        endcase
        return sz;
    endfunction

    // Loads allow 000/001/010/100/101; stores allow 000/001/010.
    function automatic logic illegal_f3(input logic wr, input logic [2:0] f3);
        logic bad;
        if (wr)
            bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        else
            bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                    f3 == F3_BU || f3 == F3_HU);
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: load extract/extend and
// sub-word store merge into a fetched word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and extend it per funct3.
    always_comb begin
        shifted  = word >> {offset, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        load_data = '0;
        unique case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            F3_W:    load_data = word;
            default: load_data = '0;
        endcase
    end

    // Insert the low store bits into the addressed lane.
    always_comb begin
        merged = word;
        case (funct3[1:0])
            2'b00: merged[{offset, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (offset[1])
                    merged[31:16] = wdata[15:0];
                else
                    merged[15:0] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding RV32I load/store initiator
// with read-modify-write for sub-word stores.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter logic [31:0] START_ADDRESS = 32'h01000000,
    parameter int          MEM_SIZE      = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_w_enable,
    input  logic [31:0] mem_data_out
);

    localparam logic [32:0] LAST_BYTE =
        33'(START_ADDRESS) + 33'(MEM_SIZE) - 33'd1;

    lsu_state_t  state, next_state;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  f3_q;
    logic        write_q;
    logic        fault_q;

    logic        misaligned;
    logic        out_of_range;
    logic        req_fault;
    logic [32:0] req_end;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    // Classify the incoming request before it is accepted.
    always_comb begin
        req_end = {1'b0, req_addr} + 33'(access_size(req_funct3)) - 33'd1;
        misaligned = 1'b0;
        if (req_funct3[1:0] == 2'b01)
            misaligned = req_addr[0];
        else if (req_funct3[1:0] == 2'b10)
            misaligned = |req_addr[1:0];
        out_of_range = (req_addr < START_ADDRESS) || (req_end > LAST_BYTE);
        req_fault = misaligned || out_of_range ||
                    illegal_f3(req_write, req_funct3);
    end

    lsu_lane u_lane (
        .funct3    (f3_q),
        .offset    (addr_q[1:0]),
        .word      (mem_data_out),
        .wdata     (data_q),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next-state and Moore output decode.
    always_comb begin
        next_state   = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_rdata   = '0;
        resp_fault   = 1'b0;
        mem_address  = {addr_q[31:2], 2'b00};
        mem_data_in  = '0;
        mem_w_enable = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready   = 1'b1;
                mem_address = START_ADDRESS;
                if (req_valid) begin
                    if (req_fault)
                        next_state = S_RESP;
                    else if (!req_write)
                        next_state = S_LOAD;
                    else if (req_funct3 == F3_W)
                        next_state = S_WRITE;
                    else
                        next_state = S_RMW_RD;
                end
            end
            S_LOAD: begin
                next_state = S_RESP;
            end
            S_RMW_RD: begin
                next_state = S_WRITE;
            end
            S_WRITE: begin
                mem_data_in  = data_q;
                mem_w_enable = 1'b1;
                next_state   = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = data_q;
                resp_fault = fault_q;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Request capture and the single data register that carries
    // store data, the merged word, or the extended load result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= START_ADDRESS;
            data_q  <= '0;
            f3_q    <= F3_B;
            write_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        f3_q    <= req_funct3;
                        write_q <= req_write;
                        fault_q <= req_fault;
                        data_q  <= req_fault ? 32'h0 : req_wdata;
                    end
                end
                S_LOAD:   data_q <= write_q ? 32'h0 : lane_load;
                S_RMW_RD: data_q <= lane_merged;
                S_WRITE:  data_q <= '0;
                default:  data_q <= data_q;
            endcase
        end
    end

endmodule
